// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants, state typedefs and the frame-length clamp used by the
// uart_baud_tx_rx transceiver.
//
// Optional build macro: UART_PARITY_EN adds a PARITY state to both FSMs.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Oversample ticks per bit period and the tick at which the receiver
    // re-checks the start bit (middle of the bit).
    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 8;

    // Legal range of data bits per frame; NBits outside it is clamped.
    localparam logic [3:0] NBITS_MIN = 4'd5;
    localparam logic [3:0] NBITS_MAX = 4'd8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // Map any NBits value onto the supported 5..8 range.
    function automatic logic [3:0] clampBits(input logic [3:0] nbits);
        if (nbits < NBITS_MIN) begin
            return NBITS_MIN;
        end else if (nbits > NBITS_MAX) begin
            return NBITS_MAX;
        end else begin
            return nbits;
        end
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Programmable oversample tick generator. A 16-bit counter runs every clock;
// when it reaches the divisor it emits a one-clock tick and reloads to 1, so
// the tick period equals the divisor in clock cycles (divisor 0/1: every clock).
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   baudRate_i  divisor, clock cycles per tick
//   tick_o      registered one-clock tick pulse
// -----------------------------------------------------------------------------
module uart_baud_tick (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] baudRate_i,
    output logic        tick_o
);

    logic [15:0] cnt_q;
    logic        tick_q;

    // The >= compare lets a lowered divisor take effect at the next compare
    // instead of waiting for the counter to wrap all the way round.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else if (cnt_q >= baudRate_i) begin
            cnt_q  <= 16'd1;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 16'd1;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_baud_tx_rx.sv
// -----------------------------------------------------------------------------
// uart_baud_tx_rx
// UART transceiver: 16x oversample tick generator, transmitter and receiver
// sharing one tick and one frame-length setting. Frame = start(0), NBits data
// bits LSB first, [even parity], stop(1).
//
// Ports:
//   Clk, Rst_n    clock, asynchronous active-low reset
//   BaudRate      clock cycles per oversample tick
//   TxEn, TxData  transmit enable and word (latched at frame start)
//   TxDone, Tx    end-of-stop-bit pulse, serial output (idle high)
//   RxEn, Rx      receive enable, serial input (idle high)
//   RxData        last received word, right-aligned
//   RxDone        one-clock pulse when a frame completes
//   RxParityErr   parity error of last frame (UART_PARITY_EN builds only)
//   NBits         data bits per frame, clamped to 5..8
//   Tick          oversample tick, for debug
//
// Optional build macro: UART_PARITY_EN (even parity bit after the data bits).
// -----------------------------------------------------------------------------
module uart_baud_tx_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = uart_pkg::OVS
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [15:0]       BaudRate,
    input  logic              TxEn,
    input  logic [DATA_W-1:0] TxData,
    output logic              TxDone,
    output logic              Tx,
    input  logic              RxEn,
    input  logic              Rx,
    output logic [DATA_W-1:0] RxData,
    output logic              RxDone,
`ifdef UART_PARITY_EN
    output logic              RxParityErr,
`endif
    input  logic [3:0]        NBits,
    output logic              Tick
);

    localparam int            TW        = $clog2(OVS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] MID_LAST  = TW'(MID_SAMPLE - 1);

    logic       tick;
    logic [3:0] nEff;

    uart_baud_tick uBaud (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .baudRate_i (BaudRate),
        .tick_o     (tick)
    );

    assign Tick = tick;
    assign nEff = clampBits(NBits);

    // ------------------------------------------------------------ transmitter
    tx_state_t         txState_q;
    logic [DATA_W-1:0] txShift_q;
    logic [TW-1:0]     txTick_q;
    logic [3:0]        txBit_q;
    logic              tx_q;
    logic              txDone_q;
`ifdef UART_PARITY_EN
    logic [DATA_W-1:0] txMask;
    logic              txPar_q;

    assign txMask = DATA_W'((32'd1 << nEff) - 32'd1);
`endif

    // Tx is registered and updated on the same edge as the state change, so
    // the line level always matches the state that is being entered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            txState_q <= TX_IDLE;
            txShift_q <= '0;
            txTick_q  <= '0;
            txBit_q   <= 4'd0;
            tx_q      <= 1'b1;
            txDone_q  <= 1'b0;
`ifdef UART_PARITY_EN
            txPar_q   <= 1'b0;
`endif
        end else begin
            txDone_q <= 1'b0;
            case (txState_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (tick && TxEn) begin
                        txShift_q <= TxData;
                        txTick_q  <= '0;
                        tx_q      <= 1'b0;
                        txState_q <= TX_START;
`ifdef UART_PARITY_EN
                        txPar_q   <= ^(TxData & txMask);
`endif
                    end
                end
                TX_START: begin
                    if (tick) begin
                        txTick_q <= (txTick_q == TICK_LAST) ? '0 : txTick_q + 1'b1;
                        if (txTick_q == TICK_LAST) begin
                            txBit_q   <= 4'd0;
                            tx_q      <= txShift_q[0];
                            txState_q <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        txTick_q <= (txTick_q == TICK_LAST) ? '0 : txTick_q + 1'b1;
                        if (txTick_q == TICK_LAST) begin
                            txShift_q <= txShift_q >> 1;
                            // >= so a mid-frame NBits decrease cannot overrun
                            if (txBit_q >= nEff - 4'd1) begin
`ifdef UART_PARITY_EN
                                tx_q      <= txPar_q;
                                txState_q <= TX_PARITY;
`else
                                tx_q      <= 1'b1;
                                txState_q <= TX_STOP;
`endif
                            end else begin
                                txBit_q <= txBit_q + 4'd1;
                                tx_q    <= txShift_q[1];
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        txTick_q <= (txTick_q == TICK_LAST) ? '0 : txTick_q + 1'b1;
                        if (txTick_q == TICK_LAST) begin
                            tx_q      <= 1'b1;
                            txState_q <= TX_STOP;
                        end
                    end
                end
`endif
                TX_STOP: begin
                    if (tick) begin
                        txTick_q <= (txTick_q == TICK_LAST) ? '0 : txTick_q + 1'b1;
                        if (txTick_q == TICK_LAST) begin
                            txDone_q  <= 1'b1;
                            txState_q <= TX_DONE;
                        end
                    end
                end
                TX_DONE: begin
                    txState_q <= TX_IDLE;
                end
                default: begin
                    tx_q      <= 1'b1;
                    txState_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign Tx     = tx_q;
    assign TxDone = txDone_q;

    // --------------------------------------------------------------- receiver
    logic [1:0]        rxSync_q;
    logic              rxIn;
    rx_state_t         rxState_q;
    logic [DATA_W-1:0] rxShift_q;
    logic [DATA_W-1:0] rxShift_d;
    logic [TW-1:0]     rxTick_q;
    logic [3:0]        rxBit_q;
    logic [DATA_W-1:0] rxData_q;
    logic              rxDone_q;
`ifdef UART_PARITY_EN
    logic              rxPar_q;
    logic              rxParErr_q;
`endif

    // Two-flop synchronizer; resets high so a reset never looks like a start.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxSync_q <= 2'b11;
        end else begin
            rxSync_q <= {rxSync_q[0], Rx};
        end
    end

    assign rxIn = rxSync_q[1];

    // New bits enter at the MSB; after NBits samples the word sits in the top
    // NBits positions and is right-aligned when RxData is loaded.
    always_comb begin
        rxShift_d = {rxIn, rxShift_q[DATA_W-1:1]};
    end

    // Receiver FSM. RxEn only gates leaving IDLE, so a frame in flight always
    // completes. The stop bit level is not checked.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxState_q  <= RX_IDLE;
            rxShift_q  <= '0;
            rxTick_q   <= '0;
            rxBit_q    <= 4'd0;
            rxData_q   <= '0;
            rxDone_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rxPar_q    <= 1'b0;
            rxParErr_q <= 1'b0;
`endif
        end else begin
            rxDone_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    if (tick && RxEn && !rxIn) begin
                        rxTick_q  <= '0;
                        rxState_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rxTick_q == MID_LAST) begin
                            rxTick_q <= '0;
                            if (!rxIn) begin
                                rxBit_q   <= 4'd0;
                                rxShift_q <= '0;
                                rxState_q <= RX_DATA;
                            end else begin
                                rxState_q <= RX_IDLE;
                            end
                        end else begin
                            rxTick_q <= rxTick_q + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rxTick_q <= (rxTick_q == TICK_LAST) ? '0 : rxTick_q + 1'b1;
                        if (rxTick_q == TICK_LAST) begin
                            rxShift_q <= rxShift_d;
                            if (rxBit_q >= nEff - 4'd1) begin
`ifdef UART_PARITY_EN
                                rxState_q <= RX_PARITY;
`else
                                rxState_q <= RX_STOP;
`endif
                            end else begin
                                rxBit_q <= rxBit_q + 4'd1;
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        rxTick_q <= (rxTick_q == TICK_LAST) ? '0 : rxTick_q + 1'b1;
                        if (rxTick_q == TICK_LAST) begin
                            // unused shift positions are zero, so ^ covers data only
                            rxPar_q   <= (^rxShift_q) ^ rxIn;
                            rxState_q <= RX_STOP;
                        end
                    end
                end
`endif
                RX_STOP: begin
                    if (tick) begin
                        rxTick_q <= (rxTick_q == TICK_LAST) ? '0 : rxTick_q + 1'b1;
                        if (rxTick_q == TICK_LAST) begin
                            rxData_q   <= rxShift_q >> (DATA_W - int'(nEff));
                            rxDone_q   <= 1'b1;
`ifdef UART_PARITY_EN
                            rxParErr_q <= rxPar_q;
`endif
                            rxState_q  <= RX_IDLE;
                        end
                    end
                end
                default: begin
                    rxState_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign RxData = rxData_q;
    assign RxDone = rxDone_q;
`ifdef UART_PARITY_EN
    assign RxParityErr = rxParErr_q;
`endif

endmodule

// File: tb/tb_uart_baud_tx_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_tx_rx
// Loopback bench for uart_baud_tx_rx. Stimulus pushes the word the receiver
// should deliver into a queue; an independent monitor pops and compares on
// every RxDone. Frame lengths and masked words come from the frame rules
// (start + data + [parity] + stop, 16 ticks per bit, NBits clamped 5..8).
// Optional build macro: UART_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_baud_tx_rx;

`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [15:0] BaudRate;
    logic        TxEn;
    logic [7:0]  TxData;
    logic        TxDone;
    logic        Tx;
    logic        RxEn;
    logic        Rx;
    logic [7:0]  RxData;
    logic        RxDone;
    logic [3:0]  NBits;
    logic        Tick;
`ifdef UART_PARITY_EN
    logic        RxParityErr;
`endif

    logic        useLoop;
    logic        rxDrv;
    int          checks    = 0;
    int          errors    = 0;
    int          cycle     = 0;
    int          rxDoneCnt = 0;
    int          txDoneCnt = 0;
    logic [7:0]  lastRx    = 8'h00;
    logic [7:0]  expQ[$];

    assign Rx = useLoop ? Tx : rxDrv;

    uart_baud_tx_rx dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .BaudRate    (BaudRate),
        .TxEn        (TxEn),
        .TxData      (TxData),
        .TxDone      (TxDone),
        .Tx          (Tx),
        .RxEn        (RxEn),
        .Rx          (Rx),
        .RxData      (RxData),
        .RxDone      (RxDone),
`ifdef UART_PARITY_EN
        .RxParityErr (RxParityErr),
`endif
        .NBits       (NBits),
        .Tick        (Tick)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle++;

    // Reference rules: effective data bits and frame length in ticks.
    function automatic int effBits(input logic [3:0] n);
        return (n < 4'd5) ? 5 : ((n > 4'd8) ? 8 : int'(n));
    endfunction

    function automatic logic [7:0] expWord(input logic [7:0] d, input logic [3:0] n);
        logic [7:0] mask;
        mask = 8'((1 << effBits(n)) - 1);
        return d & mask;
    endfunction

    function automatic int frameTicks(input logic [3:0] n);
        return (effBits(n) + 2 + PAR_BITS) * 16;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RxDone must match the oldest queued word.
    initial begin : monitor
        logic [7:0] exp;
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && RxDone === 1'b1) begin
                rxDoneCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected RxDone", 32'(RxDone), 32'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("RxData", 32'(RxData), 32'(exp));
`ifdef UART_PARITY_EN
                    checkOutput("RxParityErr", 32'(RxParityErr), 32'd0);
`endif
                end
            end
            if (Rst_n === 1'b1 && TxDone === 1'b1) txDoneCnt++;
        end
    end

    // Start one frame; returns at the negedge where Tx is first seen low.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] nbits,
                                 input bit expectRx, output int fallCycle);
        int budget;
        budget = 32 * int'(BaudRate) + 64;
        TxData = data;
        NBits  = nbits;
        if (expectRx) begin
            expQ.push_back(expWord(data, nbits));
            lastRx = expWord(data, nbits);
        end
        TxEn = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Tx === 1'b0) break;
        end
        checkOutput("Tx start bit", 32'(Tx), 32'd0);
        fallCycle = cycle;
        TxEn = 1'b0;
    endtask

    task automatic waitTxDone(output int doneCycle);
        int budget;
        budget = 20 * 16 * int'(BaudRate) + 100;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (TxDone === 1'b1) break;
        end
        checkOutput("TxDone seen", 32'(TxDone), 32'd1);
        doneCycle = cycle;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 16 * int'(BaudRate) + 64;
        for (int i = 0; i < budget && expQ.size() != 0; i++) @(negedge Clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic sendAndCheck(input logic [7:0] data, input logic [3:0] nbits);
        int f;
        int d;
        applyStimulus(data, nbits, 1'b1, f);
        waitTxDone(d);
        checkOutput("frame length", 32'(d - f), 32'(frameTicks(nbits) * int'(BaudRate)));
        waitDrain();
    endtask

    task automatic pulseReset();
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("Tx high in reset", 32'(Tx), 32'd1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int f;
        int d;
        int n;
        int txSnap;
        int rxSnap;
        int first;

        useLoop  = 1'b1;
        rxDrv    = 1'b1;
        TxEn     = 1'b0;
        RxEn     = 1'b1;
        TxData   = 8'h00;
        NBits    = 4'd8;
        BaudRate = 16'd325;
        Rst_n    = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("reset Tx", 32'(Tx), 32'd1);
        checkOutput("reset TxDone", 32'(TxDone), 32'd0);
        checkOutput("reset RxDone", 32'(RxDone), 32'd0);
        checkOutput("reset RxData", 32'(RxData), 32'd0);
        checkOutput("reset Tick", 32'(Tick), 32'd0);
        Rst_n = 1'b1;

        // Full-rate loopback frame, then reset-separated frames at a fast rate.
        $display("[TB] loopback 0xC5 at BaudRate 325");
        sendAndCheck(8'hC5, 4'd8);
        pulseReset();
        BaudRate = 16'd3;
        for (int k = 1; k <= 5; k++) begin
            sendAndCheck(8'(8'hC5 + k), 4'd8);
            pulseReset();
        end

        // Tick shape at divisor 4 and divisor 1.
        $display("[TB] tick generator");
        BaudRate = 16'd4;
        repeat (10) @(negedge Clk);
        first = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Tick === 1'b1) begin
                first = 1;
                break;
            end
        end
        checkOutput("Tick found", 32'(first), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            checkOutput("Tick period 4", 32'(Tick), ((k % 4) == 0) ? 32'd1 : 32'd0);
        end
        BaudRate = 16'd1;
        repeat (6) @(negedge Clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            checkOutput("Tick constant", 32'(Tick), 32'd1);
        end

        // Short frame: start bit is the only low period for 0xFF.
        $display("[TB] NBits 5, 0xFF");
        BaudRate = 16'd3;
        repeat (4) @(negedge Clk);
        applyStimulus(8'hFF, 4'd5, 1'b1, f);
        n = 1;
        for (int i = 0; i < 200 && Tx === 1'b0; i++) begin
            @(negedge Clk);
            if (Tx === 1'b0) n++;
        end
        checkOutput("start bit width", 32'(n), 32'(16 * 3));
        waitTxDone(d);
        checkOutput("frame length 5b", 32'(d - f), 32'(7 * 16 * 3 + PAR_BITS * 16 * 3));
        waitDrain();

        // Abort mid-DATA with reset, then resend the same word.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h5A, 4'd8, 1'b1, f);
        repeat ((16 + 3 * 16 + 8) * 3) @(negedge Clk);
        txSnap = txDoneCnt;
        rxSnap = rxDoneCnt;
        expQ.delete();
        lastRx = 8'h00;
        pulseReset();
        repeat (200 * 3) @(negedge Clk);
        checkOutput("no TxDone after abort", 32'(txDoneCnt), 32'(txSnap));
        checkOutput("no RxDone after abort", 32'(rxDoneCnt), 32'(rxSnap));
        sendAndCheck(8'h5A, 4'd8);

        // Receiver disabled: frame ignored, RxData held.
        $display("[TB] RxEn low and false start");
        RxEn   = 1'b0;
        rxSnap = rxDoneCnt;
        applyStimulus(8'h33, 4'd8, 1'b0, f);
        waitTxDone(d);
        repeat (20) @(negedge Clk);
        checkOutput("RxEn=0 no RxDone", 32'(rxDoneCnt), 32'(rxSnap));
        checkOutput("RxEn=0 RxData held", 32'(RxData), 32'(lastRx));
        RxEn    = 1'b1;
        useLoop = 1'b0;
        rxDrv   = 1'b0;
        repeat (4 * 3) @(negedge Clk);
        rxDrv   = 1'b1;
        repeat (40 * 3) @(negedge Clk);
        checkOutput("false start no RxDone", 32'(rxDoneCnt), 32'(rxSnap));
        checkOutput("false start RxData held", 32'(RxData), 32'(lastRx));
        useLoop = 1'b1;

        // RxEn dropped after the frame has started: frame still completes.
        applyStimulus(8'h3C, 4'd8, 1'b1, f);
        repeat (40 * 3) @(negedge Clk);
        RxEn = 1'b0;
        waitTxDone(d);
        waitDrain();
        RxEn = 1'b1;

        // Randomized frames: rate, length (including out-of-range) and data.
        $display("[TB] random frames");
        for (int k = 0; k < 8; k++) begin
            BaudRate = 16'($urandom_range(1, 5));
            repeat (4) @(negedge Clk);
            sendAndCheck(8'($urandom), 4'($urandom_range(0, 15)));
        end

        repeat (10) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_tx_rx.md
Name: uart_baud_tx_rx

Overview:
UART transceiver core combining three functions:
- a programmable 16x-oversampling baud tick generator;
- a transmitter;
- a receiver.
Tx and Rx share one Tick and one frame-length setting (NBits). Used standalone or looped back (Rx tied to Tx) for self-test. Frame: 1 start bit (low), NBits data bits LSB first, 1 stop bit (high).

Parameters:
- DATA_W, 8, maximum data bits per frame; width of TxData/RxData.
- OVS, 16, Tick pulses per bit period.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- BaudRate  in  16  tick divisor, in Clk cycles per Tick.
- TxEn  in  1  transmit enable.
- TxData  in  DATA_W  word to send; sampled at frame start.
- TxDone  out  1  one-Clk pulse at end of the transmitted stop bit.
- Tx  out  1  serial line out; idle high.
- RxEn  in  1  receive enable.
- Rx  in  1  serial line in; idle high.
- RxData  out  DATA_W  last received word, right-aligned, upper bits zero.
- RxDone  out  1  one-Clk pulse when a frame completes.
- NBits  in  4  data bits per frame; 5..8 valid; values >8 act as 8; values <5 act as 5.
- Tick  out  1  oversample tick, exported for debug.

Behaviour:
Reset (Rst_n low, asynchronous):
- Tx=1, TxDone=0, RxDone=0, RxData=0, Tick=0.
- All counters clear; both FSMs go to IDLE.
- Asserting reset mid-frame aborts the frame; the line returns high immediately.

Baud generator:
- 16-bit counter increments every Clk.
- When it reaches BaudRate: Tick=1 for one Clk and the counter reloads to 1. Tick period = BaudRate Clk cycles.
- BaudRate 0 or 1: Tick high every Clk.
- A change of BaudRate takes effect at the next compare.

TX FSM (IDLE, START, DATA, STOP, DONE), advancing only on Tick:
- IDLE: Tx=1. On Tick with TxEn=1, latch TxData into a shift register and go to START.
- START: Tx=0 for 16 Ticks.
- DATA: drive shift[0] for 16 Ticks per bit, then shift right; repeat NBits times.
- STOP: Tx=1 for 16 Ticks.
- DONE: TxDone=1 for exactly one Clk, then return to IDLE.
- If TxEn is still 1, the next frame starts on the next Tick (back-to-back). TxEn=0 mid-frame does not abort the frame.
- Frame length: (NBits+2)*16 Ticks.

RX FSM (IDLE, START, DATA, STOP), advancing on Tick:
- IDLE: wait for Rx=0 with RxEn=1 (Rx synchronized through 2 flops).
- START: after 8 Ticks, if Rx is still 0 go to DATA; else false start, return to IDLE.
- DATA: sample Rx every 16 Ticks (mid-bit) and shift in LSB-first; stop after NBits samples.
- STOP: after 16 more Ticks, sample the stop bit, load RxData (right-aligned via shift by 8-NBits), pulse RxDone for one Clk, return to IDLE.
- A stop bit sampled as 0 still delivers the data and RxDone (framing errors are not flagged in the base build).
- RxEn=0 holds the receiver in IDLE; a frame already in progress completes.
- RxData holds its value until the next RxDone.
- Simultaneous RxDone and TxDone are independent.

Optional Feature:
UART_PARITY_EN.
- Defined: one even-parity bit is sent after the data bits (frame = NBits+3 bits). Rx checks it and adds output RxParityErr (1 bit). RxParityErr updates together with RxDone and holds until the next RxDone; reset value 0.
- Undefined: no parity bit, no RxParityErr port.

Decomposition:
- Package uart_pkg: OVS=16, MID_SAMPLE=8, typedefs tx_state_t and rx_state_t, min/max NBits constants.
- Natural sub-module: uart_baud_tick (counter, Tick).
- Tx and Rx FSMs live in the top module.

Test Plan:
1. Loopback, BaudRate=325, NBits=8, TxEn=RxEn=1, TxData=0xC5 -> TxDone at 52000 Clk after first Tick; RxDone follows within 16*325 Clk; RxData=0xC5.
2. After each TxDone, pulse Rst_n low and increment TxData (0xC5..0xCA) -> each frame received equal to TxData; Tx=1 during reset.
3. BaudRate=4, observe Tick -> pulse every 4 Clk, width 1 Clk; BaudRate=1 -> Tick constant high.
4. NBits=5, TxData=0xFF -> Tx frame of 7 bit periods; RxData=0x1F.
5. Rst_n low at mid-DATA of 0x5A -> Tx=1 immediately, no TxDone/RxDone; next frame 0x5A received correctly.
6. RxEn=0 during a frame -> no RxDone, RxData unchanged; glitch Rx low for 4 Ticks -> false start rejected.
